// File: rtl/ram_access_master_if.sv
// Request, response and RAM-side signal bundle for ram_access_master.
// The master modport is the initiator's view; the slave modport is the host/RAM/bench view.
interface ram_access_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              mem_en;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_valid_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_en, mem_write, mem_address, mem_data,
        input  mem_data_out, mem_valid_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_en, mem_write, mem_address, mem_data,
        output mem_data_out, mem_valid_out
    );
endinterface

// File: rtl/ram_access_master.sv
// Single-outstanding initiator for the 16x32 single-port RAM with valid/ready request/response ports.
// Optional statistics counters are enabled by defining RAM_MASTER_STATS_EN.
module ram_access_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_access_master_if.master   bus,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      rd_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              req_ready_r;
    logic              mem_en_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic [DATA_W-1:0] mem_data_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              req_fire_s;
    logic              rsp_fire_s;

    // req_ready_r is only ever high in IDLE, so a fire implies IDLE
    assign req_fire_s = bus.req_valid & req_ready_r;
    assign rsp_fire_s = rsp_valid_r & bus.rsp_ready;

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_write_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and request-side handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // RAM command registers: enable pulses for the ISSUE cycle only, address/data hold between accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_r      <= 1'b0;
            mem_write_r   <= 1'b0;
            mem_address_r <= {ADDR_W{1'b0}};
            mem_data_r    <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= req_fire_s;
            if (req_fire_s) begin
                mem_write_r   <= bus.req_write;
                mem_address_r <= bus.req_addr;
                mem_data_r    <= bus.req_wdata;
            end
        end
    end

    // Response capture and hold; the RAM's valid flag is only meaningful in CAPTURE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (state_r == ST_CAPTURE) begin
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= bus.mem_data_out;
                rsp_err_r   <= ~bus.mem_valid_out;
            end else if (rsp_fire_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.mem_en      = mem_en_r;
    assign bus.mem_write   = mem_write_r;
    assign bus.mem_address = mem_address_r;
    assign bus.mem_data    = mem_data_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;

`ifdef RAM_MASTER_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [CNT_W-1:0] wr_count_r;
    logic [CNT_W-1:0] rd_count_r;

    // Completed-transaction counters, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count_r <= {CNT_W{1'b0}};
            rd_count_r <= {CNT_W{1'b0}};
        end else begin
            if ((state_r == ST_ISSUE) && mem_write_r) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
            if (rsp_fire_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
        end
    end

    assign wr_count = wr_count_r;
    assign rd_count = rd_count_r;
`else
    assign wr_count = {CNT_W{1'b0}};
    assign rd_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ram_access_master.sv
// Self-checking bench for ram_access_master: directed scenarios plus randomized traffic
// against a word-array reference of RAM contents and transaction counts.
module tb_ram_access_master;

    logic        clk;
    logic        rst;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    ram_access_master_if #(.ADDR_W(4), .DATA_W(32)) mif ();

    ram_access_master #(.ADDR_W(4), .DATA_W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (mif),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: one-cycle read latency, valid held high after reads
    logic [31:0] ram [16] = '{default: 32'd0};
    logic [31:0] ram_q = 32'd0;
    logic        ram_v = 1'b0;
    logic        force_invalid;

    always @(posedge clk) begin
        if (mif.mem_en) begin
            if (mif.mem_write) begin
                ram[mif.mem_address] <= mif.mem_data;
            end else begin
                ram_q <= ram[mif.mem_address];
                ram_v <= 1'b1;
            end
        end
    end
    assign mif.mem_data_out  = ram_q;
    assign mif.mem_valid_out = ram_v & ~force_invalid;

    // Reference model
    logic [31:0] model_mem [16];
    int          exp_wr;
    int          exp_rd;
    int          n_tests;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef RAM_MASTER_STATS_EN
        cnt_exp = (n > 65535) ? 32'd65535 : 32'(n);
`else
        cnt_exp = 32'd0;
`endif
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (mif.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (mif.req_ready !== 1'b1) check_eq("ready_timeout", 32'(mif.req_ready), 32'd1);
    endtask

    // Random junk on the request port while the master is busy; it must be ignored
    task automatic junk();
        mif.req_valid = 1'b1;
        mif.req_write = 1'($urandom);
        mif.req_addr  = 4'($urandom);
        mif.req_wdata = $urandom;
    endtask

    // Called at a negedge; returns at the negedge where req_ready is back high
    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wait_ready();
        mif.req_valid = 1'b1;
        mif.req_write = 1'b1;
        mif.req_addr  = a;
        mif.req_wdata = d;
        @(posedge clk);
        #1 junk();
        @(negedge clk);
        check_eq("wr_mem_en", 32'(mif.mem_en), 32'd1);
        check_eq("wr_mem_write", 32'(mif.mem_write), 32'd1);
        check_eq("wr_mem_addr", 32'(mif.mem_address), 32'(a));
        check_eq("wr_mem_data", mif.mem_data, d);
        check_eq("wr_busy_ready", 32'(mif.req_ready), 32'd0);
        model_mem[a] = d;
        exp_wr++;
        @(negedge clk);
        check_eq("wr_en_pulse", 32'(mif.mem_en), 32'd0);
        check_eq("wr_ready_back", 32'(mif.req_ready), 32'd1);
        check_eq("wr_no_rsp", 32'(mif.rsp_valid), 32'd0);
        check_eq("wr_count", 32'(wr_count), cnt_exp(exp_wr));
        mif.req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input int hold, input logic inv);
        wait_ready();
        force_invalid = inv;
        mif.rsp_ready = (hold == 0);
        mif.req_valid = 1'b1;
        mif.req_write = 1'b0;
        mif.req_addr  = a;
        mif.req_wdata = $urandom;
        @(posedge clk);
        #1 junk();
        @(negedge clk);
        check_eq("rd_mem_en", 32'(mif.mem_en), 32'd1);
        check_eq("rd_mem_write", 32'(mif.mem_write), 32'd0);
        check_eq("rd_mem_addr", 32'(mif.mem_address), 32'(a));
        check_eq("rd_busy_ready", 32'(mif.req_ready), 32'd0);
        @(negedge clk);
        check_eq("rd_en_pulse", 32'(mif.mem_en), 32'd0);
        check_eq("rd_early_rsp", 32'(mif.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("rd_rsp_valid", 32'(mif.rsp_valid), 32'd1);
        check_eq("rd_rdata", mif.rsp_rdata, model_mem[a]);
        check_eq("rd_err", 32'(mif.rsp_err), 32'(inv));
        check_eq("rd_resp_ready", 32'(mif.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(mif.rsp_valid), 32'd1);
            check_eq("hold_rdata", mif.rsp_rdata, model_mem[a]);
            check_eq("hold_err", 32'(mif.rsp_err), 32'(inv));
            check_eq("hold_ready", 32'(mif.req_ready), 32'd0);
            check_eq("hold_addr", 32'(mif.mem_address), 32'(a));
        end
        mif.rsp_ready = 1'b1;
        exp_rd++;
        @(negedge clk);
        check_eq("rd_rsp_done", 32'(mif.rsp_valid), 32'd0);
        check_eq("rd_ready_back", 32'(mif.req_ready), 32'd1);
        check_eq("rd_count", 32'(rd_count), cnt_exp(exp_rd));
        mif.req_valid = 1'b0;
        force_invalid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ra;
        logic [31:0] rd;
        n_tests = 0;
        n_fail  = 0;
        exp_wr  = 0;
        exp_rd  = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
        force_invalid = 1'b0;
        rst           = 1'b0;
        mif.req_valid = 1'b0;
        mif.req_write = 1'b0;
        mif.req_addr  = 4'd0;
        mif.req_wdata = 32'd0;
        mif.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(mif.req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(mif.rsp_valid), 32'd0);
        check_eq("rst_mem_en", 32'(mif.mem_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mif.mem_address), 32'd0);
        check_eq("rst_rdata", mif.rsp_rdata, 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(mif.req_ready), 32'd1);

        // 1/2: write then read back
        do_write(4'd3, 32'hDEADBEEF);
        do_read(4'd3, 0, 1'b0);
        // 3: unwritten location under back-pressure
        do_read(4'd15, 5, 1'b0);

        // 4: reset while a read is in CAPTURE
        wait_ready();
        mif.req_valid = 1'b1;
        mif.req_write = 1'b0;
        mif.req_addr  = 4'd3;
        mif.rsp_ready = 1'b1;
        @(posedge clk);
        #1 mif.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_wr = 0;
        exp_rd = 0;
        check_eq("midrst_rsp_valid", 32'(mif.rsp_valid), 32'd0);
        check_eq("midrst_ready", 32'(mif.req_ready), 32'd0);
        check_eq("midrst_mem_addr", 32'(mif.mem_address), 32'd0);
        check_eq("midrst_mem_data", mif.mem_data, 32'd0);
        check_eq("midrst_rdata", mif.rsp_rdata, 32'd0);
        check_eq("midrst_wr_count", 32'(wr_count), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("midrst_no_rsp", 32'(mif.rsp_valid), 32'd0);
        end

        // 5: back-to-back traffic
        do_write(4'd0, 32'h0123_4567);
        do_read(4'd0, 0, 1'b0);
        do_write(4'd15, 32'hA5A5_5A5A);
        do_read(4'd15, 0, 1'b0);
        check_eq("b2b_wr_count", 32'(wr_count), cnt_exp(2));
        check_eq("b2b_rd_count", 32'(rd_count), cnt_exp(2));

        // 6: RAM fails to flag valid on the capture cycle
        do_read(4'd15, 0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            ra = 4'($urandom);
            rd = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_write(ra, rd);
            end else begin
                do_read(ra, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
